// File: rtl/bus_share_arbiter.sv
// bus_share_arbiter
// Round-robin arbiter sharing one 4-bit 2:1 datapath between sources A and B.
// A request/grant handshake picks the owner, the mux select follows the
// registered grant, and the selected data is registered onto Y with a Valid
// flag. A hold counter forces a handoff when one source has kept the path
// for MAX_HOLD cycles while the other is waiting.
//
// State is one-hot so each grant output is a single register bit and never
// glitches; any illegal encoding falls back to IDLE.

module bus_share_arbiter #(
  parameter int MAX_HOLD = 8          // legal range 1..15
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic       ReqA,
  input  logic       ReqB,
  input  logic [3:0] DataA,
  input  logic [3:0] DataB,
  output logic       GntA,
  output logic       GntB,
  output logic       Sel,
  output logic [3:0] Y,
  output logic       Valid
);

  // One-hot state encoding
  localparam logic [2:0] ST_IDLE  = 3'b001;
  localparam logic [2:0] ST_GNT_A = 3'b010;
  localparam logic [2:0] ST_GNT_B = 3'b100;

  // Last counter value before a contended grant must be handed over
  localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

  // Round-robin flag encoding: which source was granted most recently
  localparam logic LAST_A = 1'b0;
  localparam logic LAST_B = 1'b1;

  logic [2:0] state_q, state_d;
  logic [3:0] hold_q,  hold_d;
  logic       last_q,  last_d;
  logic [3:0] y_q,     y_d;
  logic       valid_q, valid_d;
  logic       at_limit_s;
  logic       in_grant_s;

  assign at_limit_s = (hold_q == HOLD_LAST);
  assign in_grant_s = (state_q == ST_GNT_A) || (state_q == ST_GNT_B);

  // State, hold counter, round-robin flag and output data registers
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= ST_IDLE;
      hold_q  <= 4'd0;
      last_q  <= LAST_B;     // A wins the first tie after reset
      y_q     <= 4'b0000;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      last_q  <= last_d;
      y_q     <= y_d;
      valid_q <= valid_d;
    end
  end

  // Next-state: arbitration, direct handoff on release, forced handoff at hold limit
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (ReqA && ReqB) begin
          state_d = (last_q == LAST_B) ? ST_GNT_A : ST_GNT_B;
        end else if (ReqA) begin
          state_d = ST_GNT_A;
        end else if (ReqB) begin
          state_d = ST_GNT_B;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GNT_A: begin
        if (!ReqA) begin
          state_d = ReqB ? ST_GNT_B : ST_IDLE;
        end else if (ReqB && at_limit_s) begin
          state_d = ST_GNT_B;
        end else begin
          state_d = ST_GNT_A;
        end
      end
      ST_GNT_B: begin
        if (!ReqB) begin
          state_d = ReqA ? ST_GNT_A : ST_IDLE;
        end else if (ReqA && at_limit_s) begin
          state_d = ST_GNT_A;
        end else begin
          state_d = ST_GNT_B;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Hold counter: clear on any state change, count (saturating) while a grant is kept
  always_comb begin
    hold_d = hold_q;
    if (state_d != state_q) begin
      hold_d = 4'd0;
    end else if (in_grant_s && !at_limit_s) begin
      hold_d = hold_q + 4'd1;
    end else begin
      hold_d = hold_q;
    end
  end

  // Round-robin flag: remember the source whose grant is being entered
  always_comb begin
    last_d = last_q;
    if ((state_d == ST_GNT_A) && (state_q != ST_GNT_A)) begin
      last_d = LAST_A;
    end else if ((state_d == ST_GNT_B) && (state_q != ST_GNT_B)) begin
      last_d = LAST_B;
    end else begin
      last_d = last_q;
    end
  end

  // Datapath: capture the currently granted source, hold Y while idle
  always_comb begin
    y_d     = y_q;
    valid_d = 1'b0;
    case (state_q)
      ST_GNT_A: begin
        y_d     = DataA;
        valid_d = 1'b1;
      end
      ST_GNT_B: begin
        y_d     = DataB;
        valid_d = 1'b1;
      end
      default: begin
        y_d     = y_q;
        valid_d = 1'b0;
      end
    endcase
  end

  // Outputs decoded from registered state; select follows the B grant
  always_comb begin
    GntA  = (state_q == ST_GNT_A);
    GntB  = (state_q == ST_GNT_B);
    Sel   = (state_q == ST_GNT_B);
    Y     = y_q;
    Valid = valid_q;
  end

endmodule

// File: tb/tb_bus_share_arbiter.sv
// Directed self-checking bench for bus_share_arbiter. Two instances share the
// clock and reset: u_dut with MAX_HOLD = 8 and u_dut1 with MAX_HOLD = 1.
// Outputs are packed as {GntA, GntB, Sel, Valid, Y} and sampled 1 ns after
// the rising edge; inputs change at the same point, well before the next edge.

module tb_bus_share_arbiter;

  logic       Clk = 1'b0;
  logic       Rst_n = 1'b0;

  logic       ReqA = 1'b0, ReqB = 1'b0;
  logic [3:0] DataA = 4'h0, DataB = 4'h0;
  logic       GntA, GntB, Sel, Valid;
  logic [3:0] Y;

  logic       ReqA1 = 1'b0, ReqB1 = 1'b0;
  logic [3:0] DataA1 = 4'h0, DataB1 = 4'h0;
  logic       GntA1, GntB1, Sel1, Valid1;
  logic [3:0] Y1;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 Clk = ~Clk;

  bus_share_arbiter #(.MAX_HOLD(8)) u_dut (
    .Clk(Clk), .Rst_n(Rst_n), .ReqA(ReqA), .ReqB(ReqB),
    .DataA(DataA), .DataB(DataB), .GntA(GntA), .GntB(GntB),
    .Sel(Sel), .Y(Y), .Valid(Valid)
  );

  bus_share_arbiter #(.MAX_HOLD(1)) u_dut1 (
    .Clk(Clk), .Rst_n(Rst_n), .ReqA(ReqA1), .ReqB(ReqB1),
    .DataA(DataA1), .DataB(DataB1), .GntA(GntA1), .GntB(GntB1),
    .Sel(Sel1), .Y(Y1), .Valid(Valid1)
  );

  // Single comparison point: count it, report a mismatch
  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_chk = n_chk + 1;
    if (obs !== exp_v) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Expected packed word: {GntA, GntB, Sel, Valid, Y}
  function automatic logic [7:0] pk(input logic ga, input logic gb, input logic sl,
                                    input logic v, input logic [3:0] y);
    return {ga, gb, sl, v, y};
  endfunction

  function automatic logic [7:0] obs0();
    return {GntA, GntB, Sel, Valid, Y};
  endfunction

  function automatic logic [7:0] obs1();
    return {GntA1, GntB1, Sel1, Valid1, Y1};
  endfunction

  initial begin
    logic [3:0] ya, yb;
    int         waited;
    bit         own_b, prev_b;

    // ---------------- power-on reset ----------------
    #23;
    check_eq("por_outputs", obs0(), pk(1'b0, 1'b0, 1'b0, 1'b0, 4'h0));
    check_eq("por_outputs1", obs1(), pk(1'b0, 1'b0, 1'b0, 1'b0, 4'h0));
    Rst_n = 1'b1;
    tick();
    check_eq("por_release_idle", obs0(), pk(1'b0, 1'b0, 1'b0, 1'b0, 4'h0));

    // ---------------- single requester ----------------
    ReqA = 1'b1; DataA = 4'hA;
    tick();
    check_eq("single_grant", obs0(), pk(1'b1, 1'b0, 1'b0, 1'b0, 4'h0));
    tick();
    check_eq("single_data", obs0(), pk(1'b1, 1'b0, 1'b0, 1'b1, 4'hA));
    ReqA = 1'b0;
    tick();
    check_eq("single_release", obs0(), pk(1'b0, 1'b0, 1'b0, 1'b1, 4'hA));
    tick();
    check_eq("single_valid_low", obs0(), pk(1'b0, 1'b0, 1'b0, 1'b0, 4'hA));

    // ---------------- tie from reset, then handoff ----------------
    #2 Rst_n = 1'b0;
    #2 check_eq("tie_pre_reset", obs0(), pk(1'b0, 1'b0, 1'b0, 1'b0, 4'h0));
    Rst_n = 1'b1;
    tick();
    ReqA = 1'b1; ReqB = 1'b1; DataA = 4'h6; DataB = 4'h9;
    tick();
    check_eq("tie_a_first", obs0(), pk(1'b1, 1'b0, 1'b0, 1'b0, 4'h0));
    tick();
    check_eq("tie_a_data", obs0(), pk(1'b1, 1'b0, 1'b0, 1'b1, 4'h6));
    ReqA = 1'b0;
    tick();
    check_eq("tie_handoff", obs0(), pk(1'b0, 1'b1, 1'b1, 1'b1, 4'h6));
    tick();
    check_eq("tie_b_data", obs0(), pk(1'b0, 1'b1, 1'b1, 1'b1, 4'h9));

    // ---------------- reset mid-grant (GntB high) ----------------
    Rst_n = 1'b0;
    ReqB = 1'b0;
    #1 check_eq("midgrant_reset", obs0(), pk(1'b0, 1'b0, 1'b0, 1'b0, 4'h0));
    #2 Rst_n = 1'b1;
    tick();
    check_eq("after_reset_idle0", obs0(), pk(1'b0, 1'b0, 1'b0, 1'b0, 4'h0));
    tick();
    check_eq("after_reset_idle1", obs0(), pk(1'b0, 1'b0, 1'b0, 1'b0, 4'h0));

    // ---------------- hold limit, MAX_HOLD = 8 ----------------
    ReqA = 1'b1; ReqB = 1'b1; DataA = 4'h3; DataB = 4'h5;
    for (int k = 1; k <= 32; k++) begin
      tick();
      own_b  = (((k - 1) / 8) % 2) == 1;
      prev_b = (((k - 2) / 8) % 2) == 1;
      if (k == 1) begin
        check_eq($sformatf("hold_c%0d", k), obs0(), pk(1'b1, 1'b0, 1'b0, 1'b0, 4'h0));
      end else begin
        check_eq($sformatf("hold_c%0d", k), obs0(),
                 pk(!own_b, own_b, own_b, 1'b1, prev_b ? 4'h5 : 4'h3));
      end
    end
    ReqA = 1'b0; ReqB = 1'b0;
    tick();
    check_eq("hold_drop", obs0(), pk(1'b0, 1'b0, 1'b0, 1'b1, 4'h5));
    tick();
    check_eq("hold_idle", obs0(), pk(1'b0, 1'b0, 1'b0, 1'b0, 4'h5));

    // ---------------- no contention, then late request ----------------
    ReqA = 1'b1; DataA = 4'hC;
    for (int k = 1; k <= 20; k++) begin
      tick();
      ya = (k == 1) ? 4'h5 : 4'hC;
      check_eq($sformatf("nocont_c%0d", k), obs0(), pk(1'b1, 1'b0, 1'b0, k != 1, ya));
    end
    ReqB = 1'b1; DataB = 4'hD;
    waited = 0;
    while (!GntB && waited < 8) begin
      tick();
      waited = waited + 1;
      check_eq($sformatf("nocont_valid_w%0d", waited), {7'b0, Valid}, 8'h01);
    end
    check_eq("nocont_handoff", {7'b0, GntB}, 8'h01);
    tick();
    check_eq("nocont_b_data", obs0(), pk(1'b0, 1'b1, 1'b1, 1'b1, 4'hD));
    ReqA = 1'b0; ReqB = 1'b0;

    // ---------------- MAX_HOLD = 1, continuous contention ----------------
    check_eq("mh1_idle", obs1(), pk(1'b0, 1'b0, 1'b0, 1'b0, 4'h0));
    ReqA1 = 1'b1; ReqB1 = 1'b1; DataA1 = 4'h1; DataB1 = 4'h2;
    for (int k = 1; k <= 10; k++) begin
      tick();
      own_b = (k % 2) == 0;
      yb    = own_b ? 4'h1 : 4'h2;     // previous cycle's owner data
      if (k == 1) begin
        check_eq($sformatf("mh1_c%0d", k), obs1(), pk(1'b1, 1'b0, 1'b0, 1'b0, 4'h0));
      end else begin
        check_eq($sformatf("mh1_c%0d", k), obs1(), pk(!own_b, own_b, own_b, 1'b1, yb));
      end
    end
    ReqA1 = 1'b0; ReqB1 = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
